stop_watch_bcd: RTL and testbench
=================================

# stop_watch_bcd

Parametrised BCD stopwatch core: a prescaled tick drives a DIGITS-wide decimal counter with go/clear control, a configurable wrap or saturate policy, an overflow flag, and an optional lap-hold display. It sits between debounced button logic and the hex/7-segment display multiplexer. It replaces the fixed three-digit stopwatch in display test tops.

## Interface
- DIGITS, 4: number of BCD digits, legal range 2..8; digit 0 is the least significant.
- TICK_DIV, 5_000_000: clk cycles per LSD increment (0.1 s at 50 MHz); must be ≥ 2.
- WRAP, 1: 1 = roll over from all-9s to all-0s and continue; 0 = saturate at all-9s and stop.
- clk  in  1  system clock, all logic rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- go  in  1  level; count enable (run while 1, pause while 0).
- clr  in  1  synchronous clear, highest priority.
- lap  in  1  single-cycle pulse (debounced upstream); toggles lap hold.
- d  out  4*DIGITS  displayed BCD digits, digit i at d[4i+3:4i].
- tick  out  1  one-cycle pulse; the live count incremented this cycle.
- ovf  out  1  sticky overflow; set when the count passes all-9s.
- held  out  1  1 while the display shows a frozen lap value.

## Operation
- Reset: prescaler, live count, lap register, d, tick, ovf and held are all 0.
- Prescaler runs 0..TICK_DIV-1 while go=1 and the counter is not stopped. It holds its value while go=0, so the fraction of a period is kept across pause and resume.
- When the prescaler is at TICK_DIV-1 and enabled, it returns to 0 and the live count increments.
- Increment is a ripple BCD chain: a digit at 9 goes to 0 and carries into the next digit. No digit ever leaves 0..9.
- Overflow, when all digits are 9 and an increment occurs:
  - WRAP=1: count becomes all 0, ovf sets, counting continues.
  - WRAP=0: count holds all 9, ovf sets, prescaler freezes at 0, and no further tick is produced until clr.
- clr=1: prescaler, count, ovf, lap register and held all clear. clr overrides go, lap and any tick in the same cycle.
- lap and held: see Configuration.
- d shows the lap register when held=1, otherwise the live count.

## Timing
- All outputs are registered. d, tick and ovf change on the same edge as the increment.
- After go rises and is sampled at edge k, with the prescaler at 0, the first tick and increment appear at edge k+TICK_DIV-1. Steady running gives one tick every TICK_DIV cycles.
- clr sampled at edge k: all outputs are 0 after edge k.
- lap sampled at the same edge as an increment: the lap register captures the pre-increment count.
- reset_n assertion clears outputs immediately. Deassertion must be synchronised externally to clk.

## Configuration
- STOP_WATCH_LAP_EN defined:
  - A lap pulse while held=0 copies the live count into the lap register and sets held.
  - A lap pulse while held=1 clears held.
  - The live count keeps running underneath in both cases.
- STOP_WATCH_LAP_EN undefined:
  - lap is ignored and held is tied to 0.
  - No lap register exists; d is always the live count.

## Structure
- Shared package stop_watch_pkg holds:
  - BCD_W = 4 and BCD_MAX = 4'd9.
  - A function that returns the all-9s pattern for a given DIGITS.
- One sub-module, bcd_digit_cnt: one BCD digit with inputs inc and clr, outputs q[3:0] and carry (q==9 && inc). It is instantiated DIGITS times by a generate loop, with each carry feeding the next digit's inc.

## Test plan
Bench uses TICK_DIV=4 and DIGITS=3 unless noted.
- Run: after reset, hold go=1 for 12 cycles → tick pulses every 4 cycles and d=003.
- Pause/resume: go=1 for 6 cycles, 0 for 10 cycles, then 1 for 2 cycles → d=002 (fraction retained, no tick during pause).
- Carry and overflow:
  - Count 099 → next tick gives 100.
  - From 999 with WRAP=1 → 000, ovf=1, ticks continue.
  - From 999 with WRAP=0 → d stays 999, ovf=1, no further tick.
- Priority: clr, go=1, lap and a due tick in the same cycle → d=000, ovf=0, held=0 next cycle.
- Lap (STOP_WATCH_LAP_EN defined):
  - lap at d=005 → d frozen at 005, held=1.
  - 8 cycles later, lap again → d=007, held=0.
  - With the macro undefined, lap has no effect.
- Async reset: assert reset_n mid-count at d=042 → d, tick, ovf and held are 0 before the next clk edge.

Source files
------------

// File: rtl/stop_watch_bcd_pkg.sv
`default_nettype none
// ============================================================================
// Package : stop_watch_pkg
// Shared BCD constants and the all-9s pattern helper for the stopwatch.
// Revision: 1.0 - initial release
// ============================================================================
package stop_watch_pkg;

    localparam int         BCD_W      = 4;
    localparam logic [3:0] BCD_MAX    = 4'd9;
    localparam int         MAX_DIGITS = 8;

    // Widest pattern is returned; callers slice off the digits they use.
    function automatic logic [BCD_W*MAX_DIGITS-1:0] all_nines(input int digits);
        logic [BCD_W*MAX_DIGITS-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < digits) begin
                r[i*BCD_W +: BCD_W] = BCD_MAX;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stop_watch_bcd_if.sv
`default_nettype none
// ============================================================================
// Interface : stop_watch_bcd_if
// Control and display signals between button logic and the stopwatch core.
// Revision  : 1.0 - initial release
// ============================================================================
interface stop_watch_bcd_if
    import stop_watch_pkg::*;
#(
    parameter int DIGITS = 4
);
    logic                    go;
    logic                    clr;
    logic                    lap;
    logic [BCD_W*DIGITS-1:0] d;
    logic                    tick;
    logic                    ovf;
    logic                    held;

    modport master (output go, clr, lap, input  d, tick, ovf, held);
    modport slave  (input  go, clr, lap, output d, tick, ovf, held);
endinterface
`default_nettype wire

// File: rtl/stop_watch_bcd_digit_cnt.sv
`default_nettype none
// ============================================================================
// Module  : bcd_digit_cnt
// One BCD digit 0..9 with synchronous clear and ripple carry out.
// Revision: 1.0 - initial release
// ============================================================================
module bcd_digit_cnt
    import stop_watch_pkg::*;
(
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             clr_i,
    input  wire logic             inc_i,
    output logic [BCD_W-1:0]      q_o,
    output logic                  carry_o
);
    logic [BCD_W-1:0] q_q;
    logic [BCD_W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = '0;
        end else if (inc_i) begin
            q_d = (q_q == BCD_MAX) ? '0 : q_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o     = q_q;
    assign carry_o = (q_q == BCD_MAX) && inc_i;
endmodule
`default_nettype wire

// File: rtl/stop_watch_bcd.sv
`default_nettype none
// ============================================================================
// Module  : stop_watch_bcd
// Prescaled BCD stopwatch with wrap/saturate policy, sticky overflow and an
// optional lap-hold display enabled by STOP_WATCH_LAP_EN.
// Revision: 1.0 - initial release
// ============================================================================
module stop_watch_bcd
    import stop_watch_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 5_000_000,
    parameter int WRAP     = 1
)(
    input  wire logic          clk,
    input  wire logic          reset_n,
    stop_watch_bcd_if.slave    sw_io
);
    localparam int                          PW        = $clog2(TICK_DIV);
    localparam int                          W         = BCD_W*DIGITS;
    localparam logic [BCD_W*MAX_DIGITS-1:0] ALL9_FULL = all_nines(DIGITS);
    localparam logic [W-1:0]                ALL9      = ALL9_FULL[W-1:0];
    localparam logic [PW-1:0]               PRE_LAST  = PW'(TICK_DIV-1);

    logic [PW-1:0] pre_q, pre_d;
    logic          tick_q, tick_d;
    logic          ovf_q, ovf_d;
    logic [W-1:0]  cnt;
    logic [DIGITS:0] carry;
    logic          stopped, en, due, all9;
    logic          carry_out_unused;

    // Saturated counter stops the prescaler until cleared.
    assign stopped = (WRAP == 0) && ovf_q;
    assign en      = sw_io.go && !stopped;
    assign due     = en && (pre_q == PRE_LAST);
    assign all9    = (cnt == ALL9);

    assign carry[0] = due && !sw_io.clr && !((WRAP == 0) && all9);
    assign carry_out_unused = carry[DIGITS];

    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_digit
            bcd_digit_cnt u_digit (
                .clk     (clk),
                .rst_n   (reset_n),
                .clr_i   (sw_io.clr),
                .inc_i   (carry[i]),
                .q_o     (cnt[i*BCD_W +: BCD_W]),
                .carry_o (carry[i+1])
            );
        end
    endgenerate

    always_comb begin
        pre_d  = pre_q;
        ovf_d  = ovf_q;
        tick_d = 1'b0;
        if (sw_io.clr) begin
            pre_d = '0;
            ovf_d = 1'b0;
        end else begin
            if (due) begin
                pre_d = '0;
            end else if (en) begin
                pre_d = pre_q + 1'b1;
            end
            ovf_d  = ovf_q | (due && all9);
            tick_d = due;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_q  <= '0;
            ovf_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            ovf_q  <= ovf_d;
            tick_q <= tick_d;
        end
    end

    assign sw_io.tick = tick_q;
    assign sw_io.ovf  = ovf_q;

`ifdef STOP_WATCH_LAP_EN
    logic [W-1:0] lap_q, lap_d;
    logic         held_q, held_d;

    // Capture uses the pre-increment count, so a coincident tick is not seen.
    always_comb begin
        lap_d  = lap_q;
        held_d = held_q;
        if (sw_io.clr) begin
            lap_d  = '0;
            held_d = 1'b0;
        end else if (sw_io.lap) begin
            if (!held_q) begin
                lap_d  = cnt;
                held_d = 1'b1;
            end else begin
                held_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lap_q  <= '0;
            held_q <= 1'b0;
        end else begin
            lap_q  <= lap_d;
            held_q <= held_d;
        end
    end

    assign sw_io.d    = held_q ? lap_q : cnt;
    assign sw_io.held = held_q;
`else
    logic lap_unused;
    assign lap_unused = sw_io.lap;
    assign sw_io.d    = cnt;
    assign sw_io.held = 1'b0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_stop_watch_bcd.sv
`default_nettype none
// ============================================================================
// Module  : tb_stop_watch_bcd
// Self-checking bench: wrap and saturate instances against a decimal model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_stop_watch_bcd;
    localparam int DIG  = 3;
    localparam int TD   = 4;
    localparam int MAXV = 999;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    stop_watch_bcd_if #(.DIGITS(DIG)) b0 ();
    stop_watch_bcd_if #(.DIGITS(DIG)) b1 ();

    stop_watch_bcd #(.DIGITS(DIG), .TICK_DIV(TD), .WRAP(1)) u_wrap (
        .clk(clk), .reset_n(reset_n), .sw_io(b0.slave));
    stop_watch_bcd #(.DIGITS(DIG), .TICK_DIV(TD), .WRAP(0)) u_sat (
        .clk(clk), .reset_n(reset_n), .sw_io(b1.slave));

`ifdef STOP_WATCH_LAP_EN
    localparam bit LAP_ON = 1'b1;
`else
    localparam bit LAP_ON = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    // Model: plain decimal value plus a cycle counter per instance (0 = wrap, 1 = saturate).
    int m_cnt[2], m_pre[2], m_lapv[2];
    bit m_ovf[2], m_held[2], m_tick[2];

    typedef struct {
        logic        go;
        logic        clr;
        logic        lap;
        int          n;
        logic [11:0] d;
        logic        tick;
        logic        ovf;
    } vec_t;

    function automatic logic [11:0] bcd(input int v);
        logic [11:0] r;
        int x;
        x = v;
        r = '0;
        for (int i = 0; i < DIG; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_pre[k] = 0; m_lapv[k] = 0;
            m_ovf[k] = 0; m_held[k] = 0; m_tick[k] = 0;
        end
    endtask

    task automatic model_step(input bit g, input bit c, input bit l);
        bit wrap, en, due, lap_on;
        for (int k = 0; k < 2; k++) begin
            wrap   = (k == 0);
            lap_on = LAP_ON & l;
            if (c) begin
                m_cnt[k] = 0; m_pre[k] = 0; m_lapv[k] = 0;
                m_ovf[k] = 0; m_held[k] = 0; m_tick[k] = 0;
            end else begin
                en  = g && !(!wrap && m_ovf[k]);
                due = en && (m_pre[k] == TD-1);
                if (lap_on) begin
                    if (!m_held[k]) begin
                        m_lapv[k] = m_cnt[k];
                        m_held[k] = 1;
                    end else begin
                        m_held[k] = 0;
                    end
                end
                if (en) m_pre[k] = due ? 0 : m_pre[k] + 1;
                if (due) begin
                    if (m_cnt[k] == MAXV) begin
                        m_ovf[k] = 1;
                        m_cnt[k] = wrap ? 0 : MAXV;
                    end else begin
                        m_cnt[k] = m_cnt[k] + 1;
                    end
                end
                m_tick[k] = due;
            end
        end
    endtask

    task automatic compare_one(input int k, input logic [11:0] d, input logic t,
                               input logic o, input logic h);
        chk($sformatf("u%0d_d", k),    32'(d), 32'(bcd(m_held[k] ? m_lapv[k] : m_cnt[k])));
        chk($sformatf("u%0d_tick", k), 32'(t), 32'(m_tick[k]));
        chk($sformatf("u%0d_ovf", k),  32'(o), 32'(m_ovf[k]));
        chk($sformatf("u%0d_held", k), 32'(h), 32'(m_held[k]));
    endtask

    task automatic compare_all();
        compare_one(0, b0.d, b0.tick, b0.ovf, b0.held);
        compare_one(1, b1.d, b1.tick, b1.ovf, b1.held);
    endtask

    task automatic step(input bit g, input bit c, input bit l);
        b0.go = g; b0.clr = c; b0.lap = l;
        b1.go = g; b1.clr = c; b1.lap = l;
        @(posedge clk);
        model_step(g, c, l);
        #1;
        compare_all();
    endtask

    task automatic run_until(input int target, input int budget);
        int n;
        n = 0;
        while (m_cnt[0] != target && n < budget) begin
            step(1'b1, 1'b0, 1'b0);
            n++;
        end
        if (m_cnt[0] != target) begin
            checks++; failures++;
            $display("FAIL run_until actual=%0d required=%0d", m_cnt[0], target);
        end
    endtask

    vec_t tbl[6];
    int   t0, t1, n;

    initial begin
        tbl[0] = '{go:0, clr:1, lap:0, n:1,  d:12'h000, tick:0, ovf:0};
        tbl[1] = '{go:1, clr:0, lap:0, n:12, d:12'h003, tick:1, ovf:0};
        tbl[2] = '{go:0, clr:1, lap:0, n:1,  d:12'h000, tick:0, ovf:0};
        tbl[3] = '{go:1, clr:0, lap:0, n:6,  d:12'h001, tick:0, ovf:0};
        tbl[4] = '{go:0, clr:0, lap:0, n:10, d:12'h001, tick:0, ovf:0};
        tbl[5] = '{go:1, clr:0, lap:0, n:2,  d:12'h002, tick:1, ovf:0};

        b0.go = 0; b0.clr = 0; b0.lap = 0;
        b1.go = 0; b1.clr = 0; b1.lap = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        reset_n = 1'b1;

        // Run and pause/resume
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < tbl[i].n; j++) step(tbl[i].go, tbl[i].clr, tbl[i].lap);
            chk($sformatf("vec%0d_d", i),    32'(b0.d),    32'(tbl[i].d));
            chk($sformatf("vec%0d_tick", i), 32'(b0.tick), 32'(tbl[i].tick));
            chk($sformatf("vec%0d_ovf", i),  32'(b0.ovf),  32'(tbl[i].ovf));
        end

        // Carry chain and overflow under both policies
        step(1'b0, 1'b1, 1'b0);
        run_until(99, 500);
        chk("carry_099", 32'(b0.d), 32'h099);
        run_until(100, 8);
        chk("carry_100", 32'(b0.d), 32'h100);
        run_until(999, 4000);
        chk("wrap_999", 32'(b0.d), 32'h999);
        chk("sat_999",  32'(b1.d), 32'h999);
        n = 0;
        while (!m_ovf[0] && n < 8) begin step(1'b1, 1'b0, 1'b0); n++; end
        chk("wrap_d_000", 32'(b0.d),   32'h000);
        chk("wrap_ovf",   32'(b0.ovf), 32'h1);
        chk("sat_d_999",  32'(b1.d),   32'h999);
        chk("sat_ovf",    32'(b1.ovf), 32'h1);
        t0 = 0; t1 = 0;
        repeat (20) begin
            step(1'b1, 1'b0, 1'b0);
            t0 += int'(b0.tick);
            t1 += int'(b1.tick);
        end
        chk("wrap_ticks_continue", 32'(t0), 32'd5);
        chk("sat_no_ticks",        32'(t1), 32'd0);

        // clr beats go, lap and a due tick in the same cycle
        step(1'b0, 1'b0, 1'b1);
        n = 0;
        while (m_pre[0] != TD-1 && n < 8) begin step(1'b1, 1'b0, 1'b0); n++; end
        step(1'b1, 1'b1, 1'b1);
        chk("prio_d",    32'(b0.d),    32'h000);
        chk("prio_ovf",  32'(b0.ovf),  32'h0);
        chk("prio_held", 32'(b0.held), 32'h0);
        chk("prio_tick", 32'(b0.tick), 32'h0);
        chk("prio_sat_ovf", 32'(b1.ovf), 32'h0);

        // Lap hold
        run_until(5, 40);
        step(1'b1, 1'b0, 1'b1);
        chk("lap1_d",    32'(b0.d),    32'h005);
        chk("lap1_held", 32'(b0.held), 32'(LAP_ON));
        repeat (8) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        chk("lap2_d",    32'(b0.d),    32'h007);
        chk("lap2_held", 32'(b0.held), 32'h0);

        // Asynchronous reset right after a tick edge
        step(1'b0, 1'b1, 1'b0);
        run_until(42, 200);
        chk("pre_rst_d", 32'(b0.d), 32'h042);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_d",    32'(b0.d),    32'h0);
        chk("rst_tick", 32'(b0.tick), 32'h0);
        chk("rst_ovf",  32'(b0.ovf),  32'h0);
        chk("rst_held", 32'(b0.held), 32'h0);
        chk("rst_sat_d", 32'(b1.d),   32'h0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;

        // Randomised traffic against the model
        repeat (400) begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 99) < 2,
                 $urandom_range(0, 19) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
